sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single SDRAM controller port between three masters: video fetch (port 0), CPU (port 1), SPI/DMA (port 2).
//  Sits between the ZPU system bus/video DMA and the SDRAM controller, in the sysclk (133 MHz) domain.
//  Video has fixed priority with a burst cap. Ports 1/2 are round-robin. One transaction is outstanding at a time.
// PARAMETERS
//  ADDR_W      24  word address width (SDRAM rows+cols+bank)
//  VID_BURST   4   max consecutive video grants while port 1/2 is pending (1..15)
// PORTS
//  clk          in   1      system clock; single clock domain
//  reset_n      in   1      asynchronous, active-low reset
//  req          in   3      per-port request; held with its signals until the matching ack
//  we           in   3      per-port write enable
//  addr         in   3*ADDR_W  per-port address; port i = [i*ADDR_W +: ADDR_W]
//  wdata        in   96     per-port write data; port i = [i*32 +: 32]
//  bytesel      in   12     per-port byte enables; port i = [i*4 +: 4]
//  ack          out  3      one-cycle completion pulse to the granted port
//  rdata        out  32     read data, registered; valid in the ack cycle
//  sd_req       out  1      request to the SDRAM controller
//  sd_we        out  1      write to the controller
//  sd_addr      out  ADDR_W address to the controller
//  sd_wdata     out  32     write data to the controller
//  sd_bytesel   out  4      byte enables to the controller
//  sd_ack       in   1      controller completion pulse; sd_rdata valid with it
//  sd_rdata     in   32     controller read data
//  grant        out  2      current owner (0..2), for debug/counter display
// BEHAVIOUR
//  Reset (reset_n low, async): state=IDLE; all outputs 0; rr_last=2; vid_cnt=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: if any req is high, pick a winner and latch its we/addr/wdata/bytesel into the sd_* registers.
//    Set sd_req=1 and grant=winner next cycle, then go to BUSY. Latency from req to sd_req is 1 clk.
//   BUSY: hold sd_* stable. On sd_ack: sd_req=0, rdata<=sd_rdata, ack[grant]=1 next cycle, go to DONE.
//   DONE: ack pulse cycle, 1 clk. All req inputs are ignored this cycle, so a master that drops req on the cycle after ack is never regranted. Go to IDLE.
//  Minimum spacing between grants is therefore 3 clks plus controller latency.
//  Arbitration in IDLE:
//   req[0] wins if (req[1]|req[2])==0 or vid_cnt<VID_BURST.
//   Otherwise the round-robin port wins: first pending port after rr_last, order 1->2->1.
//  vid_cnt: +1 on each video grant while port 1/2 is pending. Cleared on any port 1/2 grant or when no low port is pending. Saturates at VID_BURST.
//  rr_last updates only on port 1/2 grants.
//  sd_ack outside BUSY is ignored and must not produce ack. A req dropped during BUSY is a protocol violation; the transaction still completes and acks.
//  sd_rdata is captured on reads and writes alike; masters ignore rdata on writes.
//  Reset asserted mid-BUSY aborts at once: sd_req=0, no ack. The controller is reset by the same reset_n.
// STRUCTURE
//  Shared package sdram_arb_pkg: PORT_VIDEO=0, PORT_CPU=1, PORT_DMA=2, NPORTS=3, state encoding localparams.
//  One sub-module, sdram_arb_pick: combinational winner select from req, rr_last, vid_cnt. Returns a 2-bit index plus a valid flag.
//  All sd_* and ack/rdata outputs are registered. No combinational path from req to sd_*.
// TESTING
//  1 Single CPU read: req=3'b010, addr=24'h000100. sd_req rises 1 clk later with sd_addr=0x000100, sd_we=0. sd_ack with sd_rdata=0xDEADBEEF gives ack=3'b010 next clk with rdata=0xDEADBEEF.
//  2 Round-robin: req[1] and req[2] held for 4 transactions. Grants go 1,2,1,2. Each ack is 1 clk wide and grant matches.
//  3 Video cap: VID_BURST=4, req=3'b111 held. Grant sequence is 0,0,0,0,1,0,0,0,0,2.
//  4 Video alone: 10 back-to-back video reqs give 10 video grants, no stall; vid_cnt stays 0.
//  5 Write passthrough: port 2 we=1, wdata=0x12345678, bytesel=4'b0011. sd_we=1 and sd_wdata/bytesel match, stable until sd_ack.
//  6 Reset mid-BUSY, and stray sd_ack in IDLE: both give sd_req=0, ack=0, grant=0. After release, the next req is served normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared port indices, FSM encoding and helpers for the SDRAM port arbiter.
// No logic of its own.
// No flow control.
package sdram_arb_pkg;

    localparam int NPORTS = 3;

    localparam logic [1:0] PORT_VIDEO = 2'd0;
    localparam logic [1:0] PORT_CPU   = 2'd1;
    localparam logic [1:0] PORT_DMA   = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [NPORTS-1:0] port_onehot(input logic [1:0] p);
        port_onehot = NPORTS'(1) << p;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner select: video by priority under a burst cap, CPU/DMA round-robin.
// Purely combinational, zero latency.
// No flow control; the caller decides when the pick is consumed.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int VID_BURST = 4
) (
    input  logic [NPORTS-1:0] req,
    input  logic [1:0]        rr_last,
    input  logic [3:0]        vid_cnt,
    output logic [1:0]        win,
    output logic              win_vld
);

    localparam logic [3:0] VID_CAP = 4'(VID_BURST);

    logic low_pend;

    always_comb begin
        low_pend = req[PORT_CPU] | req[PORT_DMA];
        win_vld  = |req;
        win      = PORT_VIDEO;
        if (req[PORT_VIDEO] && (!low_pend || vid_cnt < VID_CAP)) begin
            win = PORT_VIDEO;
        end else if (rr_last == PORT_CPU) begin
            // DMA is next in the rotation; fall back to CPU if DMA is idle
            win = req[PORT_DMA] ? PORT_DMA : PORT_CPU;
        end else begin
            win = req[PORT_CPU] ? PORT_CPU : PORT_DMA;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between video, CPU and SPI/DMA masters.
// Latency: req to sd_req 1 clk; sd_ack to ack 1 clk; one transaction outstanding.
// Backpressure: masters hold req until their ack; the controller paces via sd_ack.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int VID_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NPORTS-1:0]          req,
    input  logic [NPORTS-1:0]          we,
    input  logic [NPORTS*ADDR_W-1:0]   addr,
    input  logic [NPORTS*32-1:0]       wdata,
    input  logic [NPORTS*4-1:0]        bytesel,
    output logic [NPORTS-1:0]          ack,
    output logic [31:0]                rdata,
    output logic                       sd_req,
    output logic                       sd_we,
    output logic [ADDR_W-1:0]          sd_addr,
    output logic [31:0]                sd_wdata,
    output logic [3:0]                 sd_bytesel,
    input  logic                       sd_ack,
    input  logic [31:0]                sd_rdata,
    output logic [1:0]                 grant
);

    localparam logic [3:0] VID_CAP = 4'(VID_BURST);

    logic [1:0] state;
    logic [1:0] rr_last;
    logic [3:0] vid_cnt;
    logic [1:0] win;
    logic       win_vld;
    logic       low_pend;

    assign low_pend = req[PORT_CPU] | req[PORT_DMA];

    sdram_arb_pick #(
        .VID_BURST(VID_BURST)
    ) u_pick (
        .req     (req),
        .rr_last (rr_last),
        .vid_cnt (vid_cnt),
        .win     (win),
        .win_vld (win_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rr_last    <= PORT_DMA;
            vid_cnt    <= '0;
            ack        <= '0;
            rdata      <= '0;
            sd_req     <= 1'b0;
            sd_we      <= 1'b0;
            sd_addr    <= '0;
            sd_wdata   <= '0;
            sd_bytesel <= '0;
            grant      <= PORT_VIDEO;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (!low_pend) begin
                        vid_cnt <= '0;
                    end
                    if (win_vld) begin
                        sd_req     <= 1'b1;
                        grant      <= win;
                        sd_we      <= we[win];
                        sd_addr    <= addr[int'(win)*ADDR_W +: ADDR_W];
                        sd_wdata   <= wdata[int'(win)*32 +: 32];
                        sd_bytesel <= bytesel[int'(win)*4 +: 4];
                        state      <= ST_BUSY;
                        if (win == PORT_VIDEO) begin
                            // streak only counts while a low-priority port is starved
                            if (low_pend && vid_cnt < VID_CAP) begin
                                vid_cnt <= vid_cnt + 4'd1;
                            end
                        end else begin
                            vid_cnt <= '0;
                            rr_last <= win;
                        end
                    end
                end
                ST_BUSY: begin
                    if (sd_ack) begin
                        sd_req <= 1'b0;
                        rdata  <= sd_rdata;
                        ack    <= port_onehot(grant);
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // requests are deliberately not sampled here
                    grant <= PORT_VIDEO;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scenario and randomized checks of sdram_port_arbiter against a rule-level model.
module tb_sdram_port_arbiter;

    localparam int ADDR_W    = 24;
    localparam int VID_BURST = 4;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b1;
    logic [2:0]        req     = '0;
    logic [2:0]        we      = '0;
    logic [ADDR_W-1:0] p_addr  [3];
    logic [31:0]       p_wdata [3];
    logic [3:0]        p_bs    [3];
    logic [3*ADDR_W-1:0] addr;
    logic [95:0]       wdata;
    logic [11:0]       bytesel;
    logic [2:0]        ack;
    logic [31:0]       rdata;
    logic              sd_req;
    logic              sd_we;
    logic [ADDR_W-1:0] sd_addr;
    logic [31:0]       sd_wdata;
    logic [3:0]        sd_bytesel;
    logic              sd_ack   = 1'b0;
    logic [31:0]       sd_rdata = '0;
    logic [1:0]        grant;

    int total = 0;
    int bad   = 0;
    int m_rr_last = 2;
    int m_vid_cnt = 0;

    assign addr    = {p_addr[2], p_addr[1], p_addr[0]};
    assign wdata   = {p_wdata[2], p_wdata[1], p_wdata[0]};
    assign bytesel = {p_bs[2], p_bs[1], p_bs[0]};

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .VID_BURST (VID_BURST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .bytesel    (bytesel),
        .ack        (ack),
        .rdata      (rdata),
        .sd_req     (sd_req),
        .sd_we      (sd_we),
        .sd_addr    (sd_addr),
        .sd_wdata   (sd_wdata),
        .sd_bytesel (sd_bytesel),
        .sd_ack     (sd_ack),
        .sd_rdata   (sd_rdata),
        .grant      (grant)
    );

    task automatic rand_port(input int p);
        we[p]      = 1'($urandom);
        p_addr[p]  = ADDR_W'($urandom);
        p_wdata[p] = $urandom;
        p_bs[p]    = 4'($urandom);
    endtask

    // Reference arbiter: video first unless its streak has hit the cap while
    // CPU/DMA wait; otherwise the first waiting low port after the last one served.
    task automatic model_grant(input logic [2:0] r, output int p);
        bit low;
        int c;
        low = r[1] | r[2];
        p = -1;
        if (r[0] && (!low || m_vid_cnt < VID_BURST)) begin
            p = 0;
        end else begin
            for (int k = 1; k <= 2; k++) begin
                c = ((m_rr_last + k - 1) % 2) + 1;
                if (p < 0 && r[c]) p = c;
            end
        end
        if (p == 0) begin
            if (low) m_vid_cnt = (m_vid_cnt + 1 > VID_BURST) ? VID_BURST : m_vid_cnt + 1;
            else     m_vid_cnt = 0;
        end else if (p > 0) begin
            m_vid_cnt = 0;
            m_rr_last = p;
        end
    endtask

    // One full transaction using the current req vector; returns the DUT's grant.
    task automatic do_txn(input string name, input logic [31:0] rd, input bit drop, output int got);
        int exp;
        int waited;
        int hold;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0]       e_wd;
        logic [3:0]        e_bs;
        model_grant(req, exp);
        e_we   = we[exp];
        e_addr = p_addr[exp];
        e_wd   = p_wdata[exp];
        e_bs   = p_bs[exp];
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (sd_req !== 1'b1 && waited < 20);
        got = int'(grant);
        total++;
        if (sd_req !== 1'b1 || waited != 1) begin
            bad++;
            $display("FAIL %s req_to_sd_req: sd_req=%b after %0d clk, want 1 after 1 clk", name, sd_req, waited);
        end
        total++;
        if (grant !== 2'(exp)) begin
            bad++;
            $display("FAIL %s grant: got %0d want %0d", name, grant, exp);
        end
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) begin
            total++;
            if ({sd_req, sd_we, sd_addr, sd_wdata, sd_bytesel, ack} !== {1'b1, e_we, e_addr, e_wd, e_bs, 3'b000}) begin
                bad++;
                $display("FAIL %s busy_hold: got req=%b we=%b addr=%h wd=%h bs=%h ack=%b want 1 %b %h %h %h 000",
                         name, sd_req, sd_we, sd_addr, sd_wdata, sd_bytesel, ack, e_we, e_addr, e_wd, e_bs);
            end
            @(negedge clk);
        end
        sd_ack   = 1'b1;
        sd_rdata = rd;
        @(negedge clk);
        sd_ack   = 1'b0;
        sd_rdata = $urandom;
        total++;
        if (ack !== 3'(1 << exp) || rdata !== rd || sd_req !== 1'b0) begin
            bad++;
            $display("FAIL %s ack_cycle: got ack=%b rdata=%h sd_req=%b want ack=%b rdata=%h sd_req=0",
                     name, ack, rdata, sd_req, 3'(1 << exp), rd);
        end
        if (drop) req[exp] = 1'b0;
        else      rand_port(exp);
        @(negedge clk);
        total++;
        if (ack !== 3'b000 || sd_req !== 1'b0) begin
            bad++;
            $display("FAIL %s ack_width: got ack=%b sd_req=%b want 000 0", name, ack, sd_req);
        end
    endtask

    task automatic apply_reset(input string name);
        req    = '0;
        sd_ack = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({ack, rdata, sd_req, sd_we, sd_addr, sd_wdata, sd_bytesel, grant} !== '0) begin
            bad++;
            $display("FAIL %s reset_outputs: ack=%b rdata=%h sd_req=%b sd_we=%b addr=%h wd=%h bs=%h grant=%0d want all 0",
                     name, ack, rdata, sd_req, sd_we, sd_addr, sd_wdata, sd_bytesel, grant);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        m_rr_last = 2;
        m_vid_cnt = 0;
    endtask

    task automatic idle_gap(input int n);
        req = '0;
        repeat (n) @(negedge clk);
        m_vid_cnt = 0;
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_single_read();
        int got;
        rand_port(1);
        we[1]     = 1'b0;
        p_addr[1] = 24'h000100;
        req       = 3'b010;
        do_txn("single_read", 32'hDEADBEEF, 1'b1, got);
        total++;
        if (got != 1) begin
            bad++;
            $display("FAIL single_read owner: got %0d want 1", got);
        end
    endtask

    task automatic test_round_robin();
        int got;
        int tbl[4] = '{1, 2, 1, 2};
        apply_reset("rr_reset");
        rand_port(1);
        rand_port(2);
        req = 3'b110;
        for (int i = 0; i < 4; i++) begin
            do_txn("round_robin", $urandom, 1'b0, got);
            total++;
            if (got != tbl[i]) begin
                bad++;
                $display("FAIL round_robin seq[%0d]: got %0d want %0d", i, got, tbl[i]);
            end
        end
        idle_gap(2);
    endtask

    task automatic test_video_cap();
        int got;
        int tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
        apply_reset("cap_reset");
        for (int p = 0; p < 3; p++) rand_port(p);
        req = 3'b111;
        for (int i = 0; i < 10; i++) begin
            do_txn("video_cap", $urandom, 1'b0, got);
            total++;
            if (got != tbl[i]) begin
                bad++;
                $display("FAIL video_cap seq[%0d]: got %0d want %0d", i, got, tbl[i]);
            end
        end
        idle_gap(2);
    endtask

    task automatic test_video_alone();
        int got;
        rand_port(0);
        req = 3'b001;
        for (int i = 0; i < 10; i++) begin
            do_txn("video_alone", $urandom, 1'b0, got);
            total++;
            if (got != 0) begin
                bad++;
                $display("FAIL video_alone grant[%0d]: got %0d want 0", i, got);
            end
        end
        idle_gap(2);
    endtask

    task automatic test_write();
        int got;
        rand_port(2);
        we[2]      = 1'b1;
        p_wdata[2] = 32'h12345678;
        p_bs[2]    = 4'b0011;
        req        = 3'b100;
        do_txn("write", $urandom, 1'b1, got);
        total++;
        if (got != 2) begin
            bad++;
            $display("FAIL write owner: got %0d want 2", got);
        end
        idle_gap(2);
    endtask

    task automatic test_reset_mid_busy();
        int waited;
        int got;
        rand_port(1);
        req    = 3'b010;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (sd_req !== 1'b1 && waited < 20);
        total++;
        if (sd_req !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy start: sd_req=%b want 1", sd_req);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({sd_req, ack, grant} !== 6'b0) begin
            bad++;
            $display("FAIL mid_busy abort: sd_req=%b ack=%b grant=%0d want 0 000 0", sd_req, ack, grant);
        end
        req = '0;
        @(negedge clk);
        reset_n   = 1'b1;
        m_rr_last = 2;
        m_vid_cnt = 0;
        rand_port(1);
        req = 3'b010;
        do_txn("after_reset", $urandom, 1'b1, got);
        idle_gap(2);
    endtask

    task automatic test_stray_ack();
        int got;
        idle_gap(2);
        sd_ack   = 1'b1;
        sd_rdata = $urandom;
        @(negedge clk);
        sd_ack = 1'b0;
        total++;
        if ({sd_req, ack, grant} !== 6'b0) begin
            bad++;
            $display("FAIL stray_ack: sd_req=%b ack=%b grant=%0d want 0 000 0", sd_req, ack, grant);
        end
        @(negedge clk);
        total++;
        if ({sd_req, ack} !== 4'b0) begin
            bad++;
            $display("FAIL stray_ack later: sd_req=%b ack=%b want 0 000", sd_req, ack);
        end
        rand_port(0);
        req = 3'b001;
        do_txn("after_stray", $urandom, 1'b1, got);
        idle_gap(2);
    endtask

    task automatic test_random();
        int got;
        for (int i = 0; i < 80; i++) begin
            for (int p = 0; p < 3; p++) begin
                if (!req[p] && $urandom_range(0, 2) == 0) begin
                    rand_port(p);
                    req[p] = 1'b1;
                end
            end
            if (req == 3'b000) begin
                got = $urandom_range(0, 2);
                rand_port(got);
                req[got] = 1'b1;
            end
            do_txn("random", $urandom, 1'($urandom_range(0, 1)), got);
        end
        idle_gap(2);
    endtask

    initial begin
        for (int p = 0; p < 3; p++) begin
            p_addr[p]  = '0;
            p_wdata[p] = '0;
            p_bs[p]    = '0;
        end
        test_reset();
        test_single_read();
        test_round_robin();
        test_video_cap();
        test_video_alone();
        test_write();
        test_reset_mid_busy();
        test_stray_ack();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
